uart_mmio_responder: RTL and testbench

Memory-mapped UART responder: answers the CPU's loads and stores to the UART window at 0x8000_0000–0x8000_000F. It buffers outgoing bytes in a one-entry TX holding register and incoming bytes in a small RX FIFO. It exchanges bytes with the serial UART core over a byte-level handshake. It sits on the data-memory side of the pipeline, beside the data memory, and its read data feeds the writeback read-data mux.

---
 rtl/uart_mmio_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_mmio_responder.sv | 115 +++++++++++
 tb/tb_uart_mmio_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, status bit positions and decode helpers for
// the memory-mapped UART responder.
package uart_mmio_pkg;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] UART_RX_STAT_OFS = 4'h0;
  localparam logic [3:0] UART_TX_STAT_OFS = 4'h4;
  localparam logic [3:0] UART_TX_DATA_OFS = 4'h8;
  localparam logic [3:0] UART_RX_DATA_OFS = 4'hC;

  // Bit positions in the RX status word (+0x0)
  localparam int UART_STAT_RX_NE_BIT  = 0;
  localparam int UART_STAT_RX_OVF_BIT = 1;
  localparam int UART_STAT_TX_OVF_BIT = 2;

  // Bit position in the TX status word (+0x4)
  localparam int UART_STAT_TX_FREE_BIT = 0;

  // One-hot decode of the current CPU access
  typedef struct packed {
    logic rd_rx_stat;
    logic rd_tx_stat;
    logic rd_rx_data;
    logic wr_tx_data;
  } uart_req_t;

  // Window hit: upper 28 address bits must match the base
  function automatic logic uart_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with zero-latency head output.
// A pop on an empty FIFO is ignored; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module uart_rx_fifo
  import uart_mmio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: CPU load/store responder for the UART window.
// One-entry TX holding register, RX FIFO, registered read data.
// Optional feature macro: UART_MMIO_OVERRUN_EN adds sticky RX/TX overrun
// flags in status bits 1 and 2 (cleared by reading +0x0).
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  uart_req_t   req;
  logic        hit;
  logic [3:0]  ofs;
  logic        tx_full, tx_drain, tx_accept;
  logic [7:0]  rx_head;
  logic        rx_full, rx_empty, rx_push_ok;
  logic        rx_ovf, tx_ovf;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign hit = uart_hit(addr, BASE_ADDR);
  assign ofs = addr[3:0];

  // Decode the access into one strobe per register function
  always_comb begin
    req            = '0;
    req.rd_rx_stat = rd_en && hit && (ofs == UART_RX_STAT_OFS);
    req.rd_tx_stat = rd_en && hit && (ofs == UART_TX_STAT_OFS);
    req.rd_rx_data = rd_en && hit && (ofs == UART_RX_DATA_OFS);
    req.wr_tx_data = wr_en && hit && (ofs == UART_TX_DATA_OFS);
  end

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_valid),
    .din     (rx_data),
    .pop     (req.rd_rx_data),
    .head    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .push_ok (rx_push_ok)
  );

  // A store may refill the holding register on the same edge it drains
  assign tx_drain  = tx_full && tx_ready;
  assign tx_accept = req.wr_tx_data && (!tx_full || tx_drain);
  assign tx_valid  = tx_full;

  // TX holding register; tx_data only changes on an accepted store or reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_full <= 1'b0;
      tx_data <= '0;
    end else if (tx_accept) begin
      tx_full <= 1'b1;
      tx_data <= wdata[7:0];
    end else if (tx_drain) begin
      tx_full <= 1'b0;
    end
  end

`ifdef UART_MMIO_OVERRUN_EN
  // Sticky overrun flags; a set in the clearing cycle wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= (rx_ovf && !req.rd_rx_stat) || (rx_valid && !rx_push_ok);
      tx_ovf <= (tx_ovf && !req.rd_rx_stat) || (req.wr_tx_data && !tx_accept);
    end
  end
`else
  assign rx_ovf = 1'b0;
  assign tx_ovf = 1'b0;
`endif

  // Read mux reflects state before the edge; empty data reads return 0
  always_comb begin
    rd_mux = '0;
    if (req.rd_rx_stat) begin
      rd_mux[UART_STAT_RX_NE_BIT]  = !rx_empty;
      rd_mux[UART_STAT_RX_OVF_BIT] = rx_ovf;
      rd_mux[UART_STAT_TX_OVF_BIT] = tx_ovf;
    end else if (req.rd_tx_stat) begin
      rd_mux[UART_STAT_TX_FREE_BIT] = !tx_full;
    end else if (req.rd_rx_data && !rx_empty) begin
      rd_mux[7:0] = rx_head;
    end
  end

  // Registered load data, held until the next load
  always_ff @(posedge clk) begin
    if (!reset_n)   rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

  assign unused_ok = &{1'b0, wdata[31:8], rx_full, rx_push_ok};

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder: table-driven directed vectors plus a hand-written
// TX hold sequence. Each vector is one clock: inputs driven at the falling
// edge, outputs compared 1ns after the rising edge.
module tb_uart_mmio_responder;

  localparam logic [31:0] B = 32'h8000_0000;
`ifdef UART_MMIO_OVERRUN_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_mmio_responder #(.BASE_ADDR(32'h8000_0000), .RX_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  typedef struct {
    bit          rst;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [7:0]  wd;
    bit          trdy;
    bit          rxv;
    logic [7:0]  rxd;
    logic [31:0] e_rdata;
    bit          e_txv;
    logic [7:0]  e_txd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [7:0] wd, input bit trdy, input bit rxv,
                     input logic [7:0] rxd, input logic [31:0] e_rdata,
                     input bit e_txv, input logic [7:0] e_txd);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.trdy = trdy;
    v.rxv = rxv; v.rxd = rxd; v.e_rdata = e_rdata; v.e_txv = e_txv; v.e_txd = e_txd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    reset_n  = !v.rst;
    rd_en    = v.rd;
    wr_en    = v.wr;
    addr     = v.a;
    wdata    = {24'hDEAD_BE, v.wd};
    tx_ready = v.trdy;
    rx_valid = v.rxv;
    rx_data  = v.rxd;
    @(posedge clk);
    #1;
    chk({tag, " rdata"},    rdata,           v.e_rdata);
    chk({tag, " tx_valid"}, 32'(tx_valid),   32'(v.e_txv));
    chk({tag, " tx_data"},  32'(tx_data),    32'(v.e_txd));
  endtask

  initial begin
    vec_t h;
    reset_n = 1'b0; rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;

    //   rst rd wr addr          wd    rdy rxv rxd    e_rdata            txv txd
    add(1, 0, 0, B,          8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h00); // reset
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h00); // rx stat empty
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h00); // tx free
    add(0, 0, 1, B + 32'h8,  8'h41, 0, 0, 8'h00, 32'h1,              1, 8'h41); // load 0x41
    add(0, 0, 1, B + 32'h8,  8'h42, 0, 0, 8'h00, 32'h1,              1, 8'h41); // dropped
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h0,              1, 8'h41); // tx busy
    add(0, 0, 0, B,          8'h00, 1, 0, 8'h00, 32'h0,              0, 8'h41); // drain
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, OVF ? 32'h4 : 32'h0, 0, 8'h41); // tx ovf
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41); // cleared
    // RX ordering
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h10, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h11, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 1, 8'h12, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h10,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h11,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h12,             0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41); // empty pop
    // Decode misses
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'h14, 8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41); // out of window
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'h8,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41); // unmapped read
    add(0, 0, 1, B + 32'h4,  8'h55, 0, 0, 8'h00, 32'h0,              0, 8'h41); // wrong ofs
    add(0, 0, 1, 32'h9000_0008, 8'h66, 0, 0, 8'h00, 32'h0,           0, 8'h41); // miss
    // RX overflow: 5 bytes into depth 4
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h20, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h21, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h22, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h23, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h24, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, OVF ? 32'h3 : 32'h1, 0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h20,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h21,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h22,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h23,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41);
    // Full FIFO: push and pop on the same edge
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h30, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h31, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h32, 32'h0,              0, 8'h41);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h33, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 1, 8'h99, 32'h30,             0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h41); // no overrun
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h77, 32'h1,              0, 8'h41); // still full: drop
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h31,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h32,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h33,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h99,             0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, OVF ? 32'h2 : 32'h0, 0, 8'h41);
    // Push into empty with pop: pop sees empty, byte is kept
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 1, 8'h5A, 32'h0,              0, 8'h41);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h5A,             0, 8'h41);
    // Read and write in the same cycle; drain and reload on one edge
    add(0, 1, 1, B + 32'h8,  8'h7E, 0, 0, 8'h00, 32'h0,              1, 8'h7E);
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h0,              1, 8'h7E);
    add(0, 0, 1, B + 32'h8,  8'h7F, 1, 0, 8'h00, 32'h0,              1, 8'h7F);
    add(0, 0, 0, B,          8'h00, 1, 0, 8'h00, 32'h0,              0, 8'h7F);
    // Reset mid-transfer
    add(0, 0, 1, B + 32'h8,  8'hAB, 0, 0, 8'h00, 32'h0,              1, 8'hAB);
    add(0, 0, 0, B,          8'h00, 0, 1, 8'h01, 32'h0,              1, 8'hAB);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 1, 8'h02, 32'h1,              1, 8'hAB);
    add(1, 1, 1, B + 32'hC,  8'hCD, 1, 1, 8'h03, 32'h0,              0, 8'h00);
    add(0, 1, 0, B + 32'hC,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h00);
    add(0, 1, 0, B + 32'h0,  8'h00, 0, 0, 8'h00, 32'h0,              0, 8'h00);
    add(0, 1, 0, B + 32'h4,  8'h00, 0, 0, 8'h00, 32'h1,              0, 8'h00);

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // Hand sequence: held byte stays stable across several stalled cycles
    h = '{rst:0, rd:0, wr:1, a:B + 32'h8, wd:8'hC3, trdy:0, rxv:0, rxd:8'h00,
          e_rdata:32'h1, e_txv:1, e_txd:8'hC3};
    step("hold load", h);
    h.wr = 0;
    for (int k = 0; k < 3; k++) step($sformatf("hold stall%0d", k), h);
    h.wr = 1; h.wd = 8'hC4;
    step("hold drop", h);
    h.wr = 0; h.trdy = 1; h.e_txv = 0;
    step("hold drain", h);
    h.trdy = 0;
    step("hold idle", h);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
